// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM states and data-phase modes for the SPI NOR flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_RES       = 8'hAB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    MODE_ID,
    MODE_DEV_ID,
    MODE_READ
  } mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin plus registered rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic dly_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      dly_p2  <= RST_VAL;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      meta_p0 <= din;
      sync_p1 <= meta_p0;
      // edge pulses are registered, so a pin edge reaches the user 3 clk later
      dly_p2  <= sync_p1;
      rise    <= sync_p1 & ~dly_p2;
      fall    <= ~sync_p1 & dly_p2;
    end
  end

  assign level = sync_p1;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash emulator (0x9F, 0xAB, 0x03) with a byte-wide memory read port.
// Define SPI_FLASH_FAST_READ_EN to also accept 0x0B (fast read with 8 dummy bits).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  DEV_ID   = 8'h15,
  parameter int          ADDR_W   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic [7:0]  last_cmd,
  output logic        underrun
);

  localparam logic [23:0] ADDR_MASK = 24'((25'd1 << ADDR_W) - 25'd1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_meta_p0, mosi_sync_p1;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi_sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk) begin
    mosi_meta_p0 <= spi_mosi;
    mosi_sync_p1 <= mosi_meta_p0;
  end

  state_t      state, state_n;
  mode_t       mode, mode_n;
  logic [4:0]  bit_cnt, bit_cnt_n, dummy_last, dummy_last_n;
  logic [2:0]  tx_cnt, tx_cnt_n;
  logic [7:0]  tx_sr, tx_sr_n;
  logic [1:0]  id_idx, id_idx_n;
  logic        fast_rd, fast_n;
  logic        mem_req_n;
  logic [23:0] addr_n;
  logic        outstanding, out_n;
  logic        have_data, have_n;
  logic        stale, stale_n;
  logic        underrun_n;
  logic [7:0]  last_cmd_n;
  logic [22:0] shift_in, shift_n;
  logic [7:0]  rd_buf, buf_n;
  logic [23:0] rx_word;
  logic        rd_ok;
  logic [7:0]  rd_byte;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  endfunction

  always_comb begin
    state_n      = state;
    mode_n       = mode;
    bit_cnt_n    = bit_cnt;
    dummy_last_n = dummy_last;
    tx_cnt_n     = tx_cnt;
    tx_sr_n      = tx_sr;
    id_idx_n     = id_idx;
    fast_n       = fast_rd;
    mem_req_n    = 1'b0;
    addr_n       = mem_addr;
    out_n        = outstanding;
    have_n       = have_data;
    stale_n      = stale;
    underrun_n   = underrun;
    last_cmd_n   = last_cmd;
    shift_n      = shift_in;
    buf_n        = rd_buf;
    rx_word      = {shift_in, mosi_sync_p1};
    rd_ok        = have_data || (mem_valid && outstanding && !stale);
    rd_byte      = have_data ? rd_buf : mem_rdata;

    // A stale response belongs to a byte already sent as 0xFF; discard it and fetch the current address.
    if (mem_valid && outstanding) begin
      if (stale) begin
        stale_n   = 1'b0;
        mem_req_n = 1'b1;
      end else begin
        buf_n  = mem_rdata;
        have_n = 1'b1;
        out_n  = 1'b0;
      end
    end

    if (cs_rise) begin
      state_n   = ST_IDLE;
      out_n     = 1'b0;
      have_n    = 1'b0;
      stale_n   = 1'b0;
      mem_req_n = 1'b0;
    end else if (cs_fall) begin
      state_n   = ST_CMD;
      bit_cnt_n = 5'd0;
      tx_cnt_n  = 3'd0;
      tx_sr_n   = 8'h00;
    end else begin
      if (sclk_rise) begin
        shift_n   = rx_word[22:0];
        bit_cnt_n = bit_cnt + 5'd1;
      end
      case (state)
        ST_CMD: begin
          if (sclk_rise && bit_cnt == 5'd7) begin
            last_cmd_n = rx_word[7:0];
            bit_cnt_n  = 5'd0;
            tx_cnt_n   = 3'd0;
            fast_n     = 1'b0;
            case (rx_word[7:0])
              OP_RDID: begin
                state_n  = ST_DATA;
                mode_n   = MODE_ID;
                id_idx_n = 2'd0;
              end
              OP_RES: begin
                state_n      = ST_DUMMY;
                mode_n       = MODE_DEV_ID;
                dummy_last_n = 5'd23;
              end
              OP_READ: state_n = ST_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
              OP_FAST_READ: begin
                state_n = ST_ADDR;
                fast_n  = 1'b1;
              end
`endif
              default: state_n = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (sclk_rise && bit_cnt == 5'd23) begin
            addr_n    = rx_word & ADDR_MASK;
            mem_req_n = 1'b1;
            out_n     = 1'b1;
            have_n    = 1'b0;
            stale_n   = 1'b0;
            mode_n    = MODE_READ;
            bit_cnt_n = 5'd0;
            if (fast_rd) begin
              state_n      = ST_DUMMY;
              dummy_last_n = 5'd7;
            end else begin
              state_n = ST_DATA;
            end
          end
        end
        ST_DUMMY: begin
          if (sclk_rise && bit_cnt == dummy_last) begin
            state_n   = ST_DATA;
            bit_cnt_n = 5'd0;
          end
        end
        ST_DATA: begin
          if (sclk_fall) begin
            tx_cnt_n = tx_cnt + 3'd1;
            if (tx_cnt == 3'd0) begin
              case (mode)
                MODE_ID: begin
                  tx_sr_n  = id_byte(id_idx);
                  id_idx_n = (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                end
                MODE_DEV_ID: tx_sr_n = DEV_ID;
                default: begin
                  addr_n = (mem_addr + 24'd1) & ADDR_MASK;
                  have_n = 1'b0;
                  if (rd_ok) begin
                    tx_sr_n   = rd_byte;
                    mem_req_n = 1'b1;
                    out_n     = 1'b1;
                    stale_n   = 1'b0;
                  end else begin
                    tx_sr_n    = 8'hFF;
                    underrun_n = 1'b1;
                    if (!outstanding) begin
                      mem_req_n = 1'b1;
                      out_n     = 1'b1;
                    end
                    stale_n = outstanding && !mem_req_n;
                  end
                end
              endcase
            end else begin
              tx_sr_n = {tx_sr[6:0], 1'b0};
            end
          end
        end
        ST_IGNORE: tx_sr_n = 8'h00;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode        <= MODE_ID;
      bit_cnt     <= 5'd0;
      dummy_last  <= 5'd0;
      tx_cnt      <= 3'd0;
      tx_sr       <= 8'h00;
      id_idx      <= 2'd0;
      fast_rd     <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= 24'h0;
      outstanding <= 1'b0;
      have_data   <= 1'b0;
      stale       <= 1'b0;
      underrun    <= 1'b0;
      last_cmd    <= 8'h00;
    end else begin
      state       <= state_n;
      mode        <= mode_n;
      bit_cnt     <= bit_cnt_n;
      dummy_last  <= dummy_last_n;
      tx_cnt      <= tx_cnt_n;
      tx_sr       <= tx_sr_n;
      id_idx      <= id_idx_n;
      fast_rd     <= fast_n;
      mem_req     <= mem_req_n;
      mem_addr    <= addr_n;
      outstanding <= out_n;
      have_data   <= have_n;
      stale       <= stale_n;
      underrun    <= underrun_n;
      last_cmd    <= last_cmd_n;
    end
  end

  always_ff @(posedge clk) begin
    shift_in <= shift_n;
    rd_buf   <= buf_n;
  end

  assign spi_miso    = tx_sr[7];
  assign spi_miso_oe = ~cs_lvl;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: table of SPI transactions with MISO-byte and mem_addr scoreboards.
module tb_spi_flash_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        mem_req, mem_valid;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata, last_cmd;
  logic        underrun;

  int total = 0;
  int bad = 0;
  int req_cnt = 0;
  bit drop_next = 1'b0;

  logic [7:0]  exp_q[$];
  logic [23:0] addr_q[$];

  typedef struct {
    logic [7:0]  op;
    bit          has_addr;
    logic [23:0] addr;
    int          n_dummy;
    int          n_bytes;
    logic [31:0] exp_data;
    int          exp_reqs;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .last_cmd(last_cmd), .underrun(underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, input bit hold_high, output logic r);
    spi_mosi = b;
    wait_clk(HALF);
    r = spi_miso;
    spi_sclk = 1'b1;
    wait_clk(HALF);
    if (!hold_high) spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit hold_high, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], hold_high && (i == 0), r);
      rx[i] = r;
    end
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  // SCLK falls together with the nCS rise, so the final fall must not load another byte
  task automatic cs_end();
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    wait_clk(3);
    chk("oe_off_after_cs", spi_miso_oe, 1'b0);
    wait_clk(10);
  endtask

  task automatic check_byte(input logic [7:0] rx);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL miso_unexpected_byte got=%0h want=none", rx);
    end else begin
      chk("miso_byte", rx, exp_q.pop_front());
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] rx;
    int r0;
    for (int k = 0; k < v.n_bytes; k++) exp_q.push_back(v.exp_data[31-8*k -: 8]);
    for (int k = 0; k < v.exp_reqs; k++) addr_q.push_back(v.addr + 24'(k));
    r0 = req_cnt;
    cs_start();
    spi_byte(v.op, 1'b0, rx);
    chk("oe_on", spi_miso_oe, 1'b1);
    if (v.has_addr) begin
      spi_byte(v.addr[23:16], 1'b0, rx);
      spi_byte(v.addr[15:8], 1'b0, rx);
      spi_byte(v.addr[7:0], 1'b0, rx);
    end
    for (int k = 0; k < v.n_dummy; k++) spi_byte(8'h00, 1'b0, rx);
    for (int k = 0; k < v.n_bytes; k++) begin
      spi_byte(8'h00, k == v.n_bytes - 1, rx);
      check_byte(rx);
    end
    cs_end();
    chk("last_cmd", last_cmd, v.op);
    chk("mem_req_count", req_cnt - r0, v.exp_reqs);
    chk("mem_addr_drained", addr_q.size(), 0);
  endtask

  // memory model: returns addr[7:0] two clk after each request unless told to withhold one
  initial begin
    logic [7:0] d;
    mem_valid = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        req_cnt++;
        if (addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_req_unexpected got=%0h want=none", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, addr_q.pop_front());
        end
        if (drop_next) begin
          drop_next = 1'b0;
        end else begin
          d = mem_addr[7:0];
          @(negedge clk);
          mem_valid = 1'b1;
          mem_rdata = d;
          @(negedge clk);
          mem_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [7:0] rx;
    logic r;
    logic [11:0] half_addr;
    int r0;
    vec_t v;

    tbl[0] = '{8'h9F, 1'b0, 24'h000000, 0, 4, 32'hEF4016EF, 0};
    tbl[1] = '{8'hAB, 1'b0, 24'h000000, 3, 2, 32'h15150000, 0};
    tbl[2] = '{8'h03, 1'b1, 24'h000100, 0, 4, 32'h00010203, 5};
    tbl[3] = '{8'h03, 1'b1, 24'hFFFFFE, 0, 3, 32'hFEFF0000, 4};
    tbl[4] = '{8'h5A, 1'b0, 24'h000000, 0, 2, 32'h00000000, 0};
`ifdef SPI_FLASH_FAST_READ_EN
    tbl[5] = '{8'h0B, 1'b1, 24'h000010, 1, 2, 32'h10110000, 3};
`else
    tbl[5] = '{8'h0B, 1'b1, 24'h000010, 1, 2, 32'h00000000, 0};
`endif

    rst = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(4);
    chk("rst_miso", spi_miso, 1'b0);
    chk("rst_miso_oe", spi_miso_oe, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 24'h0);
    chk("rst_last_cmd", last_cmd, 8'h00);
    chk("rst_underrun", underrun, 1'b0);
    rst = 1'b0;
    wait_clk(4);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);
    chk("underrun_clear", underrun, 1'b0);

    // first read request never answered: 0xFF bytes and a sticky underrun
    drop_next = 1'b1;
    v = '{8'h03, 1'b1, 24'h000200, 0, 2, 32'hFFFF0000, 1};
    run_vec(v);
    chk("underrun_set", underrun, 1'b1);
    v = '{8'h9F, 1'b0, 24'h000000, 0, 1, 32'hEF000000, 0};
    run_vec(v);
    chk("underrun_sticky", underrun, 1'b1);

    // nCS rises mid-address: no request, then a clean ID read
    r0 = req_cnt;
    half_addr = 12'hA5C;
    cs_start();
    spi_byte(8'h03, 1'b0, rx);
    for (int i = 11; i >= 0; i--) spi_bit(half_addr[i], i == 0, r);
    cs_end();
    chk("abort_no_req", req_cnt - r0, 0);
    chk("abort_last_cmd", last_cmd, 8'h03);
    v = '{8'h9F, 1'b0, 24'h000000, 0, 2, 32'hEF400000, 0};
    run_vec(v);
    chk("miso_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
